// File: rtl/cw_iambic_keyer.sv
// Iambic A/B CW keyer: paddle sync/debounce, WPM element timing, PTT hang and sidetone.
// Define CW_SIDETONE_EN to build the square-wave sidetone generator; otherwise sidetone is tied low.
`timescale 1ns/1ps
module cw_iambic_keyer #(
  parameter int TICK_DIV    = 73728,
  parameter int DEBOUNCE_MS = 5,
  parameter int TONE_DIV    = 61440
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       paddle_dot_n,
  input  logic       paddle_dash_n,
  input  logic       keyer_en,
  input  logic       mode_b,
  input  logic       reverse,
  input  logic [5:0] wpm,
  input  logic [9:0] hang_ms,
  output logic       cwkey_o,
  output logic       cw_ptt,
  output logic       sidetone
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);

  typedef enum logic [1:0] {IDLE, DOT, DASH, GAP} state_t;

  state_t          state, next_state;
  logic [1:0]      dot_sync, dash_sync;
  logic [1:0]      raw_p, deb_p;
  logic [DW-1:0]   db_cnt [2];
  logic [TW-1:0]   tick_cnt;
  logic            ms_tick;
  logic [5:0]      wpm_c;
  logic [10:0]     acc, acc_sum;
  logic            unit_tick;
  logic [1:0]      unit_cnt;
  logic            dot_p, dash_p;
  logic            dot_mem, dash_mem, last_dash;
  logic            cand_dot, cand_dash;
  logic            start, key_next;
  logic [9:0]      hang_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_sync  <= 2'b11;
      dash_sync <= 2'b11;
    end else begin
      dot_sync  <= {dot_sync[0], paddle_dot_n};
      dash_sync <= {dash_sync[0], paddle_dash_n};
    end
  end

  assign raw_p = {~dash_sync[1], ~dot_sync[1]};

  // Any sample matching the debounced state restarts the count, so a short glitch never flips it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_p <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_p[i] == deb_p[i]) begin
          db_cnt[i] <= '0;
        end else if (ms_tick) begin
          if (db_cnt[i] == DB_LAST) begin
            deb_p[i]  <= raw_p[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign dot_p  = reverse ? deb_p[1] : deb_p[0];
  assign dash_p = reverse ? deb_p[0] : deb_p[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tick_cnt <= '0;
    else if (ms_tick) tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + 1'b1;
  end

  assign ms_tick = (tick_cnt == TICK_LAST);

  always_comb begin
    wpm_c = wpm;
    if (wpm < 6'd5)       wpm_c = 6'd5;
    else if (wpm > 6'd60) wpm_c = 6'd60;
  end

  assign acc_sum   = acc + {5'b0, wpm_c};
  assign unit_tick = ms_tick && (acc_sum >= 11'd1200);

  assign cand_dot  = mode_b ? dot_mem  : (dot_mem  & dot_p);
  assign cand_dash = mode_b ? dash_mem : (dash_mem & dash_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dot_p)       next_state = DOT;
        else if (dash_p) next_state = DASH;
      end
      DOT:  if (unit_tick) next_state = GAP;
      DASH: if (unit_tick && unit_cnt == 2'd2) next_state = GAP;
      GAP: begin
        if (unit_tick) begin
          if (last_dash) next_state = cand_dot  ? DOT  : (cand_dash ? DASH : IDLE);
          else           next_state = cand_dash ? DASH : (cand_dot  ? DOT  : IDLE);
        end
      end
      default: next_state = IDLE;
    endcase
    if (!keyer_en) next_state = IDLE;
  end

  assign start    = (next_state != state) && (next_state != IDLE);
  assign key_next = (next_state == DOT) || (next_state == DASH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      unit_cnt <= '0;
    end else if (start) begin
      acc      <= '0;
      unit_cnt <= '0;
    end else if (ms_tick) begin
      acc <= unit_tick ? (acc_sum - 11'd1200) : acc_sum;
      if (unit_tick) unit_cnt <= unit_cnt + 1'b1;
    end
  end

  // A memory only latches while the other element or a gap is sounding, so a paddle held
  // into its own element does not queue a repeat after the squeeze is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_mem   <= 1'b0;
      dash_mem  <= 1'b0;
      last_dash <= 1'b0;
    end else if (!keyer_en) begin
      dot_mem  <= 1'b0;
      dash_mem <= 1'b0;
    end else begin
      if (start && next_state == DOT)                      dot_mem <= 1'b0;
      else if (dot_p && (state == DASH || state == GAP))   dot_mem <= 1'b1;
      if (start && next_state == DASH)                     dash_mem <= 1'b0;
      else if (dash_p && (state == DOT || state == GAP))   dash_mem <= 1'b1;
      if (start && key_next) last_dash <= (next_state == DASH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cwkey_o <= 1'b0;
    else        cwkey_o <= key_next;
  end

  // The hang count is held at hang_ms while keyed and only runs once the key is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_ptt   <= 1'b0;
      hang_cnt <= '0;
    end else if (key_next) begin
      cw_ptt   <= 1'b1;
      hang_cnt <= hang_ms;
    end else if (cw_ptt && !cwkey_o && ms_tick) begin
      if (hang_cnt <= 10'd1) cw_ptt <= 1'b0;
      if (hang_cnt != 10'd0) hang_cnt <= hang_cnt - 1'b1;
    end
  end

`ifdef CW_SIDETONE_EN
  localparam int SW = $clog2(TONE_DIV + 1);
  localparam logic [SW-1:0] TONE_LAST = SW'(TONE_DIV - 1);
  logic [SW-1:0] tone_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      sidetone <= 1'b0;
    end else if (!key_next) begin
      tone_cnt <= '0;
      sidetone <= 1'b0;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      sidetone <= ~sidetone;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end
`else
  // No tone generator in this build: the piezo pin stays low for any legal divider.
  assign sidetone = (TONE_DIV < 0);
`endif

endmodule

// File: tb/tb_cw_iambic_keyer.sv
// Self-checking bench for cw_iambic_keyer: table-driven paddle scenarios with an element-width
// scoreboard, plus hand-written PTT hang, disable, sidetone and async-reset sequences.
`timescale 1ns/1ps
module tb_cw_iambic_keyer;

  localparam int TICK_CLKS = 10;

  logic       clk = 1'b0;
  logic       rst_n, paddle_dot_n, paddle_dash_n, keyer_en, mode_b, reverse;
  logic [5:0] wpm;
  logic [9:0] hang_ms;
  logic       cwkey_o, cw_ptt, sidetone;

  int checks = 0;
  int errors = 0;

  typedef struct { int lo; int hi; } win_t;
  win_t sb_q[$];

  typedef struct {
    bit       dot;
    bit       dash;
    bit       mode_b;
    bit       reverse;
    int       wpm;
    int       hold;
    int       run;
    int       n;
    bit [7:0] seq;
  } vec_t;

  vec_t vecs [8];

  cw_iambic_keyer #(.TICK_DIV(10), .DEBOUNCE_MS(2), .TONE_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .paddle_dot_n(paddle_dot_n), .paddle_dash_n(paddle_dash_n),
    .keyer_en(keyer_en), .mode_b(mode_b), .reverse(reverse), .wpm(wpm), .hang_ms(hang_ms),
    .cwkey_o(cwkey_o), .cw_ptt(cw_ptt), .sidetone(sidetone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  function automatic int unitClks(input int w);
    int c;
    c = (w < 5) ? 5 : (w > 60) ? 60 : w;
    return (1200 / c) * TICK_CLKS;
  endfunction

  task automatic pushElement(input bit is_dash, input int u);
    win_t w;
    int   k;
    k    = is_dash ? 3 : 1;
    w.lo = k * u - 10;
    w.hi = k * u + 1;
    sb_q.push_back(w);
  endtask

  task automatic pushAny(input int hi);
    win_t w;
    w.lo = 1;
    w.hi = hi;
    sb_q.push_back(w);
  endtask

  // Measure every key-down pulse and score it against the oldest expected element.
  int   hi_cnt = 0;
  logic key_q  = 1'b0;
  always @(negedge clk) begin
    if (cwkey_o) begin
      hi_cnt++;
    end else if (key_q) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_element_width", hi_cnt, 0);
      end else begin
        win_t w;
        w = sb_q.pop_front();
        checkRange("element_width", hi_cnt, w.lo, w.hi);
      end
      hi_cnt = 0;
    end
    key_q = cwkey_o;
  end

  task automatic waitKey(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (cwkey_o !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(cwkey_o), int'(lvl));
  endtask

  task automatic applyStimulus(input vec_t v);
    int u;
    mode_b  = v.mode_b;
    reverse = v.reverse;
    wpm     = 6'(v.wpm);
    u       = unitClks(v.wpm);
    for (int j = 0; j < v.n; j++) pushElement(v.seq[j], u);
    @(negedge clk);
    paddle_dot_n  = !v.dot;
    paddle_dash_n = !v.dash;
    repeat (v.hold) @(negedge clk);
    paddle_dot_n  = 1'b1;
    paddle_dash_n = 1'b1;
    repeat (v.run - v.hold) @(negedge clk);
  endtask

  task automatic runHang(input int h);
    int m;
    hang_ms = 10'(h);
    wpm     = 6'd20;
    mode_b  = 1'b0;
    reverse = 1'b0;
    pushElement(1'b0, unitClks(20));
    @(negedge clk);
    paddle_dot_n = 1'b0;
    waitKey(1'b1, 100, "hang_key_rise");
    checkOutput("ptt_with_key", int'(cw_ptt), 1);
    paddle_dot_n = 1'b1;
    waitKey(1'b0, 700, "hang_key_fall");
    m = 1;
    while (cw_ptt && m < 1200) begin
      @(negedge clk);
      m++;
    end
    checkRange($sformatf("ptt_hang_%0d", h), m - 1,
               ((h > 1) ? h - 1 : 0) * TICK_CLKS + 1, ((h > 1) ? h : 1) * TICK_CLKS);
    repeat (700) @(negedge clk);
  endtask

  initial begin
    int toggles;
    logic prev;

    // Scenarios at TICK_DIV=10: 1 ms = 10 clks, 20 wpm unit = 600 clks.
    vecs[0] = '{1, 0, 0, 0, 20, 5000, 6200, 5, 8'b00000};
    vecs[1] = '{1, 1, 0, 0, 20, 4000, 5000, 3, 8'b010};
    vecs[2] = '{1, 1, 1, 0, 20, 1400, 5000, 3, 8'b010};
    vecs[3] = '{1, 1, 0, 0, 20, 1400, 3800, 2, 8'b10};
    vecs[4] = '{1, 0, 0, 0, 20,   10,  200, 0, 8'b0};
    vecs[5] = '{0, 1, 0, 1, 20, 2500, 3800, 3, 8'b000};
    vecs[6] = '{1, 0, 0, 0,  2, 1000, 5000, 1, 8'b0};
    vecs[7] = '{0, 1, 0, 0, 63, 1000, 1800, 2, 8'b11};

    rst_n = 1'b0; paddle_dot_n = 1'b1; paddle_dash_n = 1'b1;
    keyer_en = 1'b1; mode_b = 1'b0; reverse = 1'b0; wpm = 6'd20; hang_ms = 10'd0;
    repeat (5) @(negedge clk);
    checkOutput("reset_cwkey", int'(cwkey_o), 0);
    checkOutput("reset_ptt", int'(cw_ptt), 0);
    checkOutput("reset_sidetone", int'(sidetone), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_pending_elements", i), sb_q.size(), 0);
      repeat (100) @(negedge clk);
    end

    runHang(50);
    runHang(0);

    // Disable mid-dash; sidetone activity is measured while keyed.
    hang_ms = 10'd0;
    wpm     = 6'd20;
    pushAny(3 * unitClks(20) + 1);
    paddle_dash_n = 1'b0;
    waitKey(1'b1, 100, "dis_key_rise");
    repeat (500) @(negedge clk);
    toggles = 0;
    prev    = sidetone;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (sidetone !== prev) toggles++;
      prev = sidetone;
    end
`ifdef CW_SIDETONE_EN
    checkOutput("sidetone_toggles", toggles, 4);
`else
    checkOutput("sidetone_toggles", toggles, 0);
`endif
    keyer_en = 1'b0;
    @(negedge clk);
    checkOutput("disable_key_drop", int'(cwkey_o), 0);
    checkOutput("disable_sidetone", int'(sidetone), 0);
    paddle_dash_n = 1'b1;
    repeat (50) @(negedge clk);
    keyer_en = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("reenable_idle", int'(cwkey_o), 0);

    // Asynchronous reset mid-dot drops everything before the next edge.
    hang_ms = 10'd100;
    pushAny(unitClks(20) + 1);
    paddle_dot_n = 1'b0;
    waitKey(1'b1, 100, "rst_key_rise");
    repeat (100) @(negedge clk);
    checkOutput("ptt_before_reset", int'(cw_ptt), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cwkey", int'(cwkey_o), 0);
    checkOutput("async_rst_ptt", int'(cw_ptt), 0);
    checkOutput("async_rst_sidetone", int'(sidetone), 0);
    paddle_dot_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("final_pending_elements", sb_q.size(), 0);
    checkOutput("final_idle", int'(cwkey_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
